// File: rtl/usb_rst_sequencer.sv
// rtl/usb_rst_sequencer.sv - USB controller reset sequencer with Avalon-MM register access
//
// Drives an active-low reset to an external USB controller: holds it low for
// ASSERT_CYC cycles, then waits RECOV_CYC cycles before reporting done. The
// power-on sequence runs out of system reset; software can rerun it via CTRL.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   address     register word address (0 CTRL, 1 ASSERT_CYC, 2 RECOV_CYC, 3 STATUS)
//   chipselect  slave select
//   write_n     write strobe, active-low
//   writedata   write data
//   readdata    read data, combinational from address
//   usb_rst_n   registered active-low reset to the USB controller
//   irq         level interrupt, done & irq_en
module usb_rst_sequencer #(
  parameter int DEF_ASSERT  = 50000,
  parameter int DEF_RECOVER = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [23:0] DEF_A24 = 24'(DEF_ASSERT);
  localparam logic [23:0] DEF_R24 = 24'(DEF_RECOVER);

  // Counter holds remaining cycles minus one, so a programmed 0 behaves as 1.
  function automatic logic [23:0] load_val(input logic [23:0] n);
    return (n == 24'd0) ? 24'd0 : n - 24'd1;
  endfunction

  state_t      state, state_nxt;
  logic [23:0] cnt, cnt_nxt;
  logic [23:0] assert_cyc, recov_cyc;
  logic [23:0] shadow_recover;
  logic        done, irq_en, busy;
  logic        usb_rst_n_q;
  logic        wr_en, start_req, seq_end;
  logic        unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign start_req = wr_en && (address == 2'd0) && writedata[0];
  assign busy      = (state != ST_IDLE);
  assign seq_end   = (state == ST_RECOVER) && (cnt == 24'd0);
  assign unused_wdata = &{1'b0, writedata[31:24]};

  // The assert length is captured straight into the counter on entry to
  // ASSERT; only the recovery length needs a separate shadow copy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = load_val(assert_cyc);
        end
      end
      ST_ASSERT: begin
        if (cnt == 24'd0) begin
          state_nxt = ST_RECOVER;
          cnt_nxt   = load_val(shadow_recover);
        end else begin
          cnt_nxt = cnt - 24'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt == 24'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 24'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ASSERT;
      cnt         <= load_val(DEF_A24);
      usb_rst_n_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      usb_rst_n_q <= (state_nxt != ST_ASSERT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert_cyc     <= DEF_A24;
      recov_cyc      <= DEF_R24;
      shadow_recover <= DEF_R24;
      done           <= 1'b0;
      irq_en         <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          2'd0:    irq_en     <= writedata[1];
          2'd1:    assert_cyc <= writedata[23:0];
          2'd2:    recov_cyc  <= writedata[23:0];
          default: ;
        endcase
      end
      if (state == ST_IDLE && start_req) begin
        shadow_recover <= recov_cyc;
      end
      // Sequence completion takes priority over a STATUS clear in the same cycle.
      if (seq_end) begin
        done <= 1'b1;
      end else if ((wr_en && address == 2'd3) || (state == ST_IDLE && start_req)) begin
        done <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {29'd0, done, irq_en, busy};
      2'd1:    readdata = {8'd0, assert_cyc};
      2'd2:    readdata = {8'd0, recov_cyc};
      default: readdata = {31'd0, done};
    endcase
  end

  assign usb_rst_n = usb_rst_n_q;
  assign irq       = done & irq_en;

endmodule

// File: doc/usb_rst_sequencer.md
USB_RST_SEQUENCER -- requirements
Module: usb_rst_sequencer

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Parameter DEF_ASSERT, default 50000, meaning reset-assert cycles after system reset (1 ms at 50 MHz).
REQ-003 Parameter DEF_RECOVER, default 500000, meaning post-release recovery cycles (10 ms at 50 MHz).
REQ-004 Port clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port address  input  2  Avalon-MM word address.
REQ-007 Port chipselect  input  1  Avalon-MM slave select.
REQ-008 Port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 Port writedata  input  32  Avalon-MM write data.
REQ-010 Port readdata  output  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-011 Port usb_rst_n  output  1  active-low reset to the USB controller chip.
REQ-012 Port irq  output  1  level interrupt, high while done=1 and irq_en=1.

Function
REQ-013 Write qualifier: chipselect=1 and write_n=0; reads have no side effects.
REQ-014 Addr 0 CTRL: write bit0=1 requests start, bit1 sets irq_en; read {29'b0, done, irq_en, busy}.
REQ-015 Addr 1 ASSERT_CYC: 24-bit, writedata[23:0]; read zero-extended.
REQ-016 Addr 2 RECOV_CYC: 24-bit, writedata[23:0]; read zero-extended.
REQ-017 Addr 3 STATUS: any write clears done; reads return {31'b0, done}.
REQ-018 States: IDLE, ASSERT, RECOVER; busy=1 in ASSERT and RECOVER.
REQ-019 IDLE -> ASSERT on start request; ASSERT_CYC and RECOV_CYC are snapshotted into shadow registers in that cycle.
REQ-020 ASSERT: usb_rst_n=0 for exactly max(shadow_assert,1) cycles, then RECOVER.
REQ-021 RECOVER: usb_rst_n=1 for exactly max(shadow_recover,1) cycles, then IDLE with done set in the same edge.
REQ-022 usb_rst_n SHALL be registered, glitch-free, and low only in ASSERT.
REQ-023 Start request while busy=1 SHALL be ignored; no restart, no queueing.
REQ-024 Register writes while busy SHALL update the register but not the running sequence.
REQ-025 Counter SHALL be a 24-bit down-counter; no wrap below zero; value 0 treated as 1.
REQ-026 Simultaneous done-set (RECOVER exit) and STATUS write: set wins, done=1.
REQ-027 Start in IDLE with done=1 SHALL clear done on entry to ASSERT.
REQ-028 irq SHALL be combinational from done and irq_en.

Reset
REQ-029 On reset: state=ASSERT, ASSERT_CYC=DEF_ASSERT, RECOV_CYC=DEF_RECOVER, shadows loaded with the same, done=0, irq_en=0.
REQ-030 Reset values: usb_rst_n=0, irq=0, readdata follows address from reset registers.
REQ-031 After reset deassertion the power-on sequence SHALL run as any software-started sequence (REQ-020/021).
REQ-032 Reset mid-sequence SHALL abort and restart the power-on sequence with defaults; software values are lost.

Verification
REQ-033 DEF_ASSERT=4, DEF_RECOVER=6; release reset -> usb_rst_n low 4 cycles, high; busy clears after 6 more; done=1.
REQ-034 Write ASSERT_CYC=10, RECOV_CYC=3, CTRL=0x3 in IDLE -> usb_rst_n low exactly 10 cycles, busy 13 cycles, then irq=1; STATUS write -> irq=0.
REQ-035 ASSERT_CYC=0, RECOV_CYC=0, start -> 1 low cycle, 1 recovery cycle, done=1.
REQ-036 Start during ASSERT and ASSERT_CYC=100 written during RECOVER -> sequence length unchanged; readback of addr 1 = 100.
REQ-037 STATUS write in the RECOVER exit cycle -> done reads 1 afterwards.
REQ-038 Reset pulse mid-RECOVER -> usb_rst_n=0 next cycle, CTRL reads 0x1, ASSERT_CYC reads DEF_ASSERT.
